// File: rtl/t03_text_bitmap_builder.sv
// Text bitmap builder: walks a 12-character ASCII string, fetches each glyph
// row from an external font ROM into a shadow buffer, then commits the whole
// 108x8 bitmap to the text output in a single cycle.
module t03_text_bitmap_builder #(
    parameter int NUM_CHARS  = 12,
    parameter int GLYPH_ROWS = 8,
    parameter int CELL_W     = 9,
    localparam int ROW_W     = NUM_CHARS * CELL_W,
    localparam int TEXT_W    = ROW_W * GLYPH_ROWS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*NUM_CHARS-1:0] chars,
    output logic [7:0]             font_char,
    output logic [2:0]             font_row,
    input  logic [7:0]             font_bits,
    output logic [TEXT_W-1:0]      text,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_LATCH  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    localparam int CHARS_W = 8 * NUM_CHARS;

    logic [1:0]         state_reg;
    logic [CHARS_W-1:0] chars_sh_reg;     // latched string, current cell in the top byte
    logic [TEXT_W-1:0]  shadow_reg;
    logic [TEXT_W-1:0]  text_reg;
    logic [3:0]         k_reg;
    logic [2:0]         r_reg;
    logic [9:0]         row_base_reg;     // r * ROW_W, built by accumulation
    logic [9:0]         cell_base_reg;    // k * CELL_W, built by accumulation
    logic [7:0]         font_char_reg;
    logic [2:0]         font_row_reg;
    logic               done_reg;

    logic [7:0]         cur_char;
    logic [7:0]         safe_char;
    logic [9:0]         wr_hi;
    logic               last_fetch;

    // Current cell code, with non-printable codes shown as a space; plus the
    // shadow index of the glyph's leftmost pixel for the current (k, r).
    always_comb begin
        cur_char   = chars_sh_reg[CHARS_W-1 -: 8];
        safe_char  = ((cur_char >= 8'h20) && (cur_char <= 8'h7E)) ? cur_char : 8'h20;
        wr_hi      = 10'(TEXT_W - 1) - (row_base_reg + cell_base_reg);
        last_fetch = (k_reg == 4'(NUM_CHARS - 1)) && (r_reg == 3'(GLYPH_ROWS - 1));
    end

    // Build sequencer: fetch/latch each glyph row, then commit atomically.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            chars_sh_reg  <= '0;
            shadow_reg    <= '0;
            text_reg      <= '0;
            k_reg         <= '0;
            r_reg         <= '0;
            row_base_reg  <= '0;
            cell_base_reg <= '0;
            font_char_reg <= '0;
            font_row_reg  <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        chars_sh_reg  <= chars;
                        shadow_reg    <= '0;
                        k_reg         <= '0;
                        r_reg         <= '0;
                        row_base_reg  <= '0;
                        cell_base_reg <= '0;
                        state_reg     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    font_char_reg <= safe_char;
                    font_row_reg  <= r_reg;
                    state_reg     <= ST_LATCH;
                end
                ST_LATCH: begin
                    // Bit 7 is the leftmost pixel, so it takes the highest index.
                    shadow_reg[wr_hi -: 8] <= font_bits;
                    if (r_reg != 3'(GLYPH_ROWS - 1)) begin
                        r_reg        <= r_reg + 3'd1;
                        row_base_reg <= row_base_reg + 10'(ROW_W);
                    end else begin
                        r_reg         <= '0;
                        row_base_reg  <= '0;
                        k_reg         <= k_reg + 4'd1;
                        cell_base_reg <= cell_base_reg + 10'(CELL_W);
                        chars_sh_reg  <= {chars_sh_reg[CHARS_W-9:0], 8'h00};
                    end
                    state_reg <= last_fetch ? ST_COMMIT : ST_FETCH;
                end
                default: begin
                    text_reg  <= shadow_reg;
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign font_char = font_char_reg;
    assign font_row  = font_row_reg;
    assign text      = text_reg;
    assign done      = done_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_t03_text_bitmap_builder.sv
// Directed testbench for t03_text_bitmap_builder with a combinational font
// ROM model and a per-bit expected-bitmap model.
module tb_t03_text_bitmap_builder;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [95:0]  chars;
    logic [7:0]   font_char;
    logic [2:0]   font_row;
    logic [7:0]   font_bits;
    logic [863:0] text;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;
    bit rom_ones = 1'b0;

    always #5 clk = ~clk;

    t03_text_bitmap_builder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .chars     (chars),
        .font_char (font_char),
        .font_row  (font_row),
        .font_bits (font_bits),
        .text      (text),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [7:0] rom_val(input logic [7:0] c, input logic [2:0] r, input bit ones);
        logic [7:0] a;
        logic [7:0] b;
        if (ones) return 8'hFF;
        a = c * 8'd37;
        b = {5'd0, r} * 8'd91;
        return a ^ b ^ 8'h5A;
    endfunction

    always_comb font_bits = rom_val(font_char, font_row, rom_ones);

    function automatic logic [7:0] sub_code(input logic [7:0] c);
        return (c >= 8'h20 && c <= 8'h7E) ? c : 8'h20;
    endfunction

    function automatic logic [7:0] cell_of(input logic [95:0] s, input int k);
        return s[95 - 8*k -: 8];
    endfunction

    function automatic logic [863:0] exp_map(input logic [95:0] s, input bit ones);
        logic [863:0] m;
        logic [7:0]   g;
        m = '0;
        for (int k = 0; k < 12; k++) begin
            for (int r = 0; r < 8; r++) begin
                g = rom_val(sub_code(cell_of(s, k)), 3'(r), ones);
                for (int j = 0; j < 8; j++)
                    m[863 - (r*108 + 9*k + j)] = g[7 - j];
            end
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one edge (E0) with the given string.
    task automatic kick(input logic [95:0] s);
        chars = s;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; chars = '0;
        step(); step();
        n_cmp++; if (text !== '0) begin n_bad++; $display("FAIL reset_text got=%h want=0", text); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (font_char !== 8'h00) begin n_bad++; $display("FAIL reset_font_char got=%h want=00", font_char); end
        n_cmp++; if (font_row !== 3'd0) begin n_bad++; $display("FAIL reset_font_row got=%0d want=0", font_row); end
        rst = 1'b0;
        step();
        $display("test_reset: done");
    endtask

    task automatic test_all_ones();
        int early_done;
        logic [8:0] sl;
        rom_ones = 1'b1;
        early_done = 0;
        kick("AAAAAAAAAAAA");
        for (int e = 1; e <= 192; e++) begin
            step();
            if (done) early_done++;
        end
        n_cmp++; if (early_done != 0) begin n_bad++; $display("FAIL ones_early_done got=%0d want=0", early_done); end
        step(); // E193
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ones_done_E193 got=%b want=1", done); end
        n_cmp++; if (text[863:855] !== 9'b111111110) begin n_bad++; $display("FAIL ones_cell0 got=%b want=111111110", text[863:855]); end
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 12; k++) begin
                sl = text[863 - (r*108 + 9*k) -: 9];
                n_cmp++;
                if (sl !== 9'b111111110) begin
                    n_bad++;
                    $display("FAIL ones_slice r=%0d k=%0d got=%b want=111111110", r, k, sl);
                end
            end
        end
        n_cmp++; if (text[0] !== 1'b0) begin n_bad++; $display("FAIL ones_text0 got=%b want=0", text[0]); end
        n_cmp++; if (text[1] !== 1'b1) begin n_bad++; $display("FAIL ones_text1 got=%b want=1", text[1]); end
        step(); // E194
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ones_done_E194 got=%b want=0", done); end
        $display("test_all_ones: done");
    endtask

    task automatic test_hello();
        logic [95:0] s;
        logic [863:0] prev;
        int p;
        s = "HELLO WORLD!";
        prev = text;
        rom_ones = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hello_busy_pre got=%b want=0", busy); end
        kick(s);
        for (int e = 1; e <= 192; e++) begin
            step();
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hello_busy e=%0d got=%b want=1", e, busy); end
            if (e % 2 == 1) begin
                p = (e - 1) / 2;
                n_cmp++;
                if (font_char !== cell_of(s, p / 8) || font_row !== 3'(p % 8)) begin
                    n_bad++;
                    $display("FAIL hello_font pair=%0d got=%h/%0d want=%h/%0d", p, font_char, font_row, cell_of(s, p / 8), p % 8);
                end
                if (p == 0) begin
                    n_cmp++; if (font_char !== 8'h48) begin n_bad++; $display("FAIL hello_first_char got=%h want=48", font_char); end
                end
                if (p == 95) begin
                    n_cmp++; if (font_char !== 8'h21 || font_row !== 3'd7) begin n_bad++; $display("FAIL hello_last got=%h/%0d want=21/7", font_char, font_row); end
                end
            end
        end
        n_cmp++; if (text !== prev) begin n_bad++; $display("FAIL hello_text_held got=%h want=%h", text, prev); end
        step(); // E193
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hello_busy_E193 got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL hello_done got=%b want=1", done); end
        n_cmp++; if (text !== exp_map(s, 1'b0)) begin n_bad++; $display("FAIL hello_text got=%h want=%h", text, exp_map(s, 1'b0)); end
        step();
        $display("test_hello: done");
    endtask

    task automatic test_substitution();
        logic [95:0] s;
        logic [8:0] sl;
        int p;
        s = {"ABC", 8'h0A, "DEFGHIJ", 8'h80};
        kick(s);
        for (int e = 1; e <= 192; e++) begin
            step();
            if (e % 2 == 1) begin
                p = (e - 1) / 2;
                if (p / 8 == 3 || p / 8 == 11) begin
                    n_cmp++;
                    if (font_char !== 8'h20) begin n_bad++; $display("FAIL subst_font pair=%0d got=%h want=20", p, font_char); end
                end
            end
        end
        step(); // E193
        n_cmp++; if (text !== exp_map(s, 1'b0)) begin n_bad++; $display("FAIL subst_text got=%h want=%h", text, exp_map(s, 1'b0)); end
        sl = text[863 - 27 -: 9];
        n_cmp++; if (sl !== {rom_val(8'h20, 3'd0, 1'b0), 1'b0}) begin n_bad++; $display("FAIL subst_cell3_row0 got=%b want=%b", sl, {rom_val(8'h20, 3'd0, 1'b0), 1'b0}); end
        sl = text[863 - (7*108 + 99) -: 9];
        n_cmp++; if (sl !== {rom_val(8'h20, 3'd7, 1'b0), 1'b0}) begin n_bad++; $display("FAIL subst_cell11_row7 got=%b want=%b", sl, {rom_val(8'h20, 3'd7, 1'b0), 1'b0}); end
        step();
        $display("test_substitution: done");
    endtask

    task automatic test_back_to_back();
        logic [95:0] s1;
        logic [95:0] s2;
        s1 = "FIRST STRING";
        s2 = "SECOND TEXT!";
        kick(s1);
        for (int e = 1; e <= 193; e++) step();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done1 got=%b want=1", done); end
        // start while done is high is accepted
        kick(s2);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_E0 got=%b want=1", busy); end
        for (int e = 1; e <= 192; e++) begin
            start = (e == 50);
            if (e == 60) chars = "ZZZZZZZZZZZZ";
            step();
            start = 1'b0;
            if (e == 51) begin
                n_cmp++; if (font_char !== 8'h4F || font_row !== 3'd1) begin n_bad++; $display("FAIL b2b_no_restart got=%h/%0d want=4f/1", font_char, font_row); end
            end
        end
        n_cmp++; if (text !== exp_map(s1, 1'b0)) begin n_bad++; $display("FAIL b2b_text_held got=%h want=%h", text, exp_map(s1, 1'b0)); end
        start = 1'b1; // ignored during COMMIT
        step(); // E193
        start = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done2 got=%b want=1", done); end
        n_cmp++; if (text !== exp_map(s2, 1'b0)) begin n_bad++; $display("FAIL b2b_text2 got=%h want=%h", text, exp_map(s2, 1'b0)); end
        step();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL b2b_no_queue busy=%b done=%b want=0/0", busy, done); end
        $display("test_back_to_back: done");
    endtask

    task automatic test_reset_mid();
        int dcnt;
        logic [95:0] s;
        dcnt = 0;
        kick("RESET TEST 1");
        for (int e = 1; e <= 99; e++) step();
        rst = 1'b1;
        step(); // edge 100
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
        n_cmp++; if (text !== '0) begin n_bad++; $display("FAIL rmid_text got=%h want=0", text); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rmid_done got=%b want=0", done); end
        for (int e = 0; e < 200; e++) begin
            step();
            if (done) dcnt++;
        end
        n_cmp++; if (dcnt != 0) begin n_bad++; $display("FAIL rmid_done_pulses got=%0d want=0", dcnt); end
        s = "AFTER RESET!";
        kick(s);
        for (int e = 1; e <= 192; e++) step();
        n_cmp++; if (done !== 1'b0 || text !== '0) begin n_bad++; $display("FAIL rmid_early done=%b text_nonzero=%b want=0/0", done, |text); end
        step(); // E193
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rmid_done_fresh got=%b want=1", done); end
        n_cmp++; if (text !== exp_map(s, 1'b0)) begin n_bad++; $display("FAIL rmid_text_fresh got=%h want=%h", text, exp_map(s, 1'b0)); end
        step();
        $display("test_reset_mid: done");
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_hello();
        test_substitution();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
